// File: rtl/add_result_streamer_pkg.sv
// Shared defaults and helpers for the int8 feature-row streamer.
// Rows are packed filter-major: filter m occupies a contiguous H*DATA_WIDTH slice.
package add_result_streamer_pkg;

  localparam int DEF_H          = 24;
  localparam int DEF_K          = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ROWS       = 24;

  localparam int FILT_W = $clog2(DEF_K);
  localparam int ROW_W  = $clog2(DEF_ROWS);

  // Bit offset of filter m's slice inside a packed row.
  function automatic int sliceOffset(input int m, input int h, input int dw);
    return m * h * dw;
  endfunction

endpackage

// File: rtl/fmap_pingpong_buf.sv
// Two-slot row buffer: captures whole rows on push and releases the head row on pop.
// A push that lands on a full buffer is only accepted if the head row leaves in the same cycle.
module fmap_pingpong_buf
  import add_result_streamer_pkg::*;
#(
  parameter int ROW_BITS = DEF_H * DEF_K * DEF_DATA_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_push,
  input  logic [0:ROW_BITS-1] i_pushData,
  input  logic                i_pop,
  output logic [0:ROW_BITS-1] o_headRow,
  output logic [1:0]          o_count,
  output logic                o_overflow
);

  logic [0:ROW_BITS-1] r_slot [2];
  logic                r_wrSel;
  logic                r_rdSel;
  logic [1:0]          r_count;
  logic                r_overflow;

  logic                w_release;
  logic                w_accept;

  assign w_release = i_pop && (r_count != 2'd0);
  assign w_accept  = i_push && ((r_count != 2'd2) || w_release);

  // Slot storage carries no reset; its contents are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_slot[r_wrSel] <= i_pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wrSel    <= 1'b0;
      r_rdSel    <= 1'b0;
      r_count    <= 2'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wrSel <= ~r_wrSel;
      end
      if (w_release) begin
        r_rdSel <= ~r_rdSel;
      end
      if (i_push && !w_accept) begin
        r_overflow <= 1'b1;
      end
      case ({w_accept, w_release})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_headRow  = r_slot[r_rdSel];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/add_result_streamer.sv
// Receives packed int8 result rows and streams them one filter slice per beat over valid/ready,
// tracking filter and row position within a frame.
module add_result_streamer
  import add_result_streamer_pkg::*;
#(
  parameter int H          = DEF_H,
  parameter int K          = DEF_K,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ROWS       = DEF_ROWS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [0:H*K*DATA_WIDTH-1]     data_i,
  input  logic                          done_i,
  output logic [0:H*DATA_WIDTH-1]       out_data_o,
  output logic [$clog2(K)-1:0]          out_filter_o,
  output logic [$clog2(ROWS)-1:0]       out_row_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          out_last_o,
  output logic                          frame_done_o,
  output logic                          overflow_o,
  output logic                          busy_o
);

  localparam int ROW_BITS  = H * K * DATA_WIDTH;
  localparam int BEAT_BITS = H * DATA_WIDTH;
  localparam int FW        = $clog2(K);
  localparam int RW        = $clog2(ROWS);
  localparam int SEL_W     = $clog2(ROW_BITS);
  localparam logic [FW-1:0] LAST_FILTER = FW'(K - 1);
  localparam logic [RW-1:0] LAST_ROW    = RW'(ROWS - 1);

  logic [FW-1:0]       r_filterIdx;
  logic [RW-1:0]       r_rowIdx;
  logic                r_frameDone;

  logic [0:ROW_BITS-1] w_headRow;
  logic [1:0]          w_count;
  logic                w_overflow;
  logic                w_valid;
  logic                w_fire;
  logic                w_rowEnd;
  logic [SEL_W-1:0]    w_sliceBase;

  assign w_valid  = (w_count != 2'd0);
  assign w_fire   = w_valid && out_ready_i;
  assign w_rowEnd = w_fire && (r_filterIdx == LAST_FILTER);

  fmap_pingpong_buf #(
    .ROW_BITS (ROW_BITS)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (done_i),
    .i_pushData (data_i),
    .i_pop      (w_rowEnd),
    .o_headRow  (w_headRow),
    .o_count    (w_count),
    .o_overflow (w_overflow)
  );

  // Filter index walks the head row; row index advances each time a row is released.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_filterIdx <= '0;
      r_rowIdx    <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= w_rowEnd && (r_rowIdx == LAST_ROW);
      if (w_fire) begin
        if (w_rowEnd) begin
          r_filterIdx <= '0;
          r_rowIdx    <= (r_rowIdx == LAST_ROW) ? '0 : r_rowIdx + 1'b1;
        end else begin
          r_filterIdx <= r_filterIdx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_sliceBase = SEL_W'(sliceOffset(int'(r_filterIdx), H, DATA_WIDTH));
    out_data_o  = '0;
    if (w_valid) begin
      out_data_o = w_headRow[w_sliceBase +: BEAT_BITS];
    end
  end

  assign out_valid_o  = w_valid;
  assign out_filter_o = r_filterIdx;
  assign out_row_o    = r_rowIdx;
  assign out_last_o   = w_valid && (r_filterIdx == LAST_FILTER) && (r_rowIdx == LAST_ROW);
  assign frame_done_o = r_frameDone;
  assign overflow_o   = w_overflow;
  assign busy_o       = w_valid;

endmodule

// File: tb/tb_add_result_streamer.sv
// Randomized bench for add_result_streamer; a queue-of-rows reference model predicts every output each cycle.
module tb_add_result_streamer;
  import add_result_streamer_pkg::*;

  localparam int H         = DEF_H;
  localparam int K         = DEF_K;
  localparam int DW        = DEF_DATA_WIDTH;
  localparam int ROWS      = 4;
  localparam int ROW_BITS  = H * K * DW;
  localparam int BEAT_BITS = H * DW;
  localparam int STORE     = 64;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [0:ROW_BITS-1]       data_i;
  logic                      done_i;
  logic [0:BEAT_BITS-1]      out_data_o;
  logic [$clog2(K)-1:0]      out_filter_o;
  logic [$clog2(ROWS)-1:0]   out_row_o;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic                      out_last_o;
  logic                      frame_done_o;
  logic                      overflow_o;
  logic                      busy_o;

  int checks = 0;
  int fails  = 0;
  bit checkEn = 1'b0;
  int cycle = 0;

  // Reference model: rows are byte arrays, the buffer is a plain queue of row ids.
  logic [7:0] rowStore [STORE][K][H];
  int nextId = 0;
  int q[$];
  int mFilter = 0;
  int mRow = 0;
  bit mOverflow = 1'b0;
  bit mFrameDone = 1'b0;

  always #5 clk = ~clk;

  add_result_streamer #(
    .H          (H),
    .K          (K),
    .DATA_WIDTH (DW),
    .ROWS       (ROWS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_i       (data_i),
    .done_i       (done_i),
    .out_data_o   (out_data_o),
    .out_filter_o (out_filter_o),
    .out_row_o    (out_row_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_last_o   (out_last_o),
    .frame_done_o (frame_done_o),
    .overflow_o   (overflow_o),
    .busy_o       (busy_o)
  );

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  // kind 0: byte(m,n) = m*16+n; otherwise random bytes.
  task automatic makeRow(input int kind, output int id);
    id = nextId;
    nextId = (nextId + 1) % STORE;
    for (int m = 0; m < K; m++) begin
      for (int n = 0; n < H; n++) begin
        rowStore[id][m][n] = (kind == 0) ? 8'(m * 16 + n) : 8'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic compareAll();
    logic [0:BEAT_BITS-1] expBeat;
    bit expValid;
    expValid = (q.size() != 0);
    expBeat = '0;
    if (expValid) begin
      for (int n = 0; n < H; n++) begin
        expBeat[n*DW +: DW] = rowStore[q[0]][mFilter][n];
      end
    end
    checkOutput("valid",      256'(out_valid_o),  256'(expValid));
    checkOutput("data",       256'(out_data_o),   256'(expBeat));
    checkOutput("filter",     256'(out_filter_o), 256'(mFilter));
    checkOutput("row",        256'(out_row_o),    256'(mRow));
    checkOutput("last",       256'(out_last_o),   256'(expValid && mFilter == K - 1 && mRow == ROWS - 1));
    checkOutput("frame_done", 256'(frame_done_o), 256'(mFrameDone));
    checkOutput("overflow",   256'(overflow_o),   256'(mOverflow));
    checkOutput("busy",       256'(busy_o),       256'(expValid));
  endtask

  // One clock: check current outputs at the falling edge, drive inputs, advance the model.
  task automatic applyStimulus(input bit rst, input bit done, input int id, input bit ready);
    bit fire;
    bit rel;
    @(negedge clk);
    if (checkEn) compareAll();
    cycle++;
    rst_n = rst;
    done_i = done;
    out_ready_i = ready;
    data_i = '0;
    if (done) begin
      for (int m = 0; m < K; m++) begin
        for (int n = 0; n < H; n++) begin
          data_i[sliceOffset(m, H, DW) + n*DW +: DW] = rowStore[id][m][n];
        end
      end
    end
    if (rst) begin
      q.delete();
      mFilter = 0;
      mRow = 0;
      mOverflow = 1'b0;
      mFrameDone = 1'b0;
    end else begin
      fire = (q.size() != 0) && ready;
      rel = fire && (mFilter == K - 1);
      mFrameDone = rel && (mRow == ROWS - 1);
      if (fire) begin
        if (rel) begin
          void'(q.pop_front());
          mFilter = 0;
          mRow = (mRow + 1) % ROWS;
        end else begin
          mFilter++;
        end
      end
      if (done) begin
        if (q.size() < 2) q.push_back(id);
        else mOverflow = 1'b1;
      end
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int idA, idB, idC, idD;
    rst_n = 1'b1;
    done_i = 1'b0;
    data_i = '0;
    out_ready_i = 1'b0;

    $display("[TB] reset and single row");
    doReset();
    checkEn = 1'b1;
    makeRow(0, idA);
    applyStimulus(1'b0, 1'b1, idA, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b0, 0, 1'b1);

    $display("[TB] backpressure");
    makeRow(1, idA);
    applyStimulus(1'b0, 1'b1, idA, 1'b0);
    for (int i = 0; i < 32; i++) applyStimulus(1'b0, 1'b0, 0, (i % 4 == 0) || (i % 4 == 3));

    $display("[TB] overflow");
    makeRow(1, idA);
    makeRow(1, idB);
    makeRow(1, idC);
    applyStimulus(1'b0, 1'b1, idA, 1'b0);
    applyStimulus(1'b0, 1'b1, idB, 1'b0);
    applyStimulus(1'b0, 1'b1, idC, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 0, 1'b0);
    repeat (20) applyStimulus(1'b0, 1'b0, 0, 1'b1);

    $display("[TB] capture coinciding with release");
    doReset();
    makeRow(1, idA);
    makeRow(1, idB);
    makeRow(1, idD);
    applyStimulus(1'b0, 1'b1, idA, 1'b0);
    applyStimulus(1'b0, 1'b1, idB, 1'b0);
    repeat (7) applyStimulus(1'b0, 1'b0, 0, 1'b1);
    applyStimulus(1'b0, 1'b1, idD, 1'b1);
    repeat (20) applyStimulus(1'b0, 1'b0, 0, 1'b1);

    $display("[TB] frame wrap");
    doReset();
    for (int r = 0; r < ROWS; r++) begin
      makeRow(1, idA);
      applyStimulus(1'b0, 1'b1, idA, 1'b1);
      repeat (7) applyStimulus(1'b0, 1'b0, 0, 1'b1);
    end
    repeat (6) applyStimulus(1'b0, 1'b0, 0, 1'b1);

    $display("[TB] mid-stream reset");
    doReset();
    makeRow(1, idA);
    applyStimulus(1'b0, 1'b1, idA, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 0, 1'b1);
    applyStimulus(1'b1, 1'b0, 0, 1'b1);
    makeRow(0, idB);
    applyStimulus(1'b0, 1'b1, idB, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b0, 0, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      bit d;
      d = ($urandom_range(0, 2) == 0);
      if (d) makeRow(1, idA);
      applyStimulus(1'b0, d, idA, $urandom_range(0, 3) != 0);
    end
    applyStimulus(1'b0, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
